float_mac_dot_sequencer: RTL and testbench
==========================================

Name: float_mac_dot_sequencer

Overview:
- Sequences a float multiply-add datapath with a Kulisch accumulator over streamed operand vectors.
- Accepts (a, b) pairs on a valid/ready stream with a `last` marker and accumulates exactly.
- Emits one fixed-point dot-product result per vector on a buffered valid/ready output, then restarts from zero with no bubble.
- Sits between the operand fetch/packer and the Kulisch-to-float rounding stage.

Parameters:
- EXP_IN_A, 3, exponent bits of operand a.
- FRAC_IN_A, 2, fraction bits of operand a.
- EXP_IN_B, 3, exponent bits of operand b.
- FRAC_IN_B, 2, fraction bits of operand b.
- TRAILING_BITS, 2, passed to the multiplier.
- ACC_DESIRED, 32, total accumulator width; 0 selects the minimum width plus ACC_EXTRA_BIT.
- ACC_EXTRA_BIT, 8, guard integer bits used when ACC_DESIRED=0.
- OVERFLOW_DETECTION, 0, passed to the fixed-point conversion and add.
- MAX_LEN, 1024, count saturation limit; CNT_W = $clog2(MAX_LEN+1).

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  pair accepted when in_valid && in_ready.
- in_a  in  1+EXP_IN_A+FRAC_IN_A  float {sign, exp, frac}.
- in_b  in  1+EXP_IN_B+FRAC_IN_B  float {sign, exp, frac}.
- in_last  in  1  final pair of the current vector.
- out_valid  out  1  result buffer full.
- out_ready  in  1  consumer takes result.
- out_acc  out  ACC_TOTAL  Kulisch result, two's complement, ACC_FRAC fraction bits.
- out_count  out  CNT_W  pairs in the vector (saturates at MAX_LEN).

Behaviour:
- Widths:
  - ACC_FRAC = (FRAC_IN_A+FRAC_IN_B+1) + 2^(EXP_IN_A-1) + 2^(EXP_IN_B-1) - 2.
  - ACC_NON_FRAC = ACC_DESIRED - ACC_FRAC when ACC_DESIRED != 0, else ACC_EXTRA_BIT + 2 + 2^(EXP_IN_A-1) + 2^(EXP_IN_B-1).
  - Defaults give ACC_FRAC=11, ACC_TOTAL=32.
- Reset: s1_valid, s1_last, acc, cnt, out_valid, out_acc, out_count all 0. in_ready reads 1 in the cycle after reset deasserts.
- Pipeline:
  - Stage S1 registers {a, b, last} on accept.
  - The MAC is combinational from S1 operands and acc to the next acc.
  - The acc register is written when S1 retires.
  - Latency: a pair accepted in cycle t is in acc at the end of t+1. out_valid rises in cycle t+2 after the last pair is accepted at t.
- stall = s1_valid && s1_last && out_valid && !out_ready. in_ready = !stall.
- S1 retires when s1_valid && !stall. S1 loads on accept; otherwise it clears on retire; otherwise it holds.
- Retire of a non-last pair: acc <= mac, cnt <= sat(cnt+1).
- Retire of a last pair: out_acc <= mac, out_count <= sat(cnt+1), out_valid <= 1, acc <= 0, cnt <= 0. The next vector's first pair may retire in the following cycle.
- Output buffer: out_valid clears on out_ready unless a last retires in the same cycle; then it stays 1 with new data.
- FSM on the output buffer:
  - EMPTY→FULL on last retire.
  - FULL→EMPTY on out_ready with no last retire.
  - FULL→FULL on out_ready with a simultaneous last retire.
  - FULL holds while stalled.
- Single-pair vector (in_last on the first pair) is legal: result = a*b, count = 1.
- Accumulator overflow wraps mod 2^ACC_TOTAL unless OVERFLOW_DETECTION saturates it in the datapath. The controller adds no check.
- Count saturates at MAX_LEN; accumulation continues.
- Reset mid-vector or with a result pending discards all state. No partial result is emitted.
- in_* are ignored when !in_valid. in_last is meaningful only on accept.

Decomposition:
- Package float_mac_pkg: functions acc_frac(), acc_non_frac(), acc_total() over the parameters; state enum {OUT_EMPTY, OUT_FULL}.
- Sub-module: existing FloatMultiplyAdd, instantiated with a combinational path from operands and accIn to accOut.
- The controller owns all registers: S1, acc, cnt, output buffer.

Test Plan:
- Vector [(1.0,1.0), (2.0,0.5), (-0.5,2.0)] with last on the 3rd, out_ready=1 → out_valid 2 cycles after the 3rd accept; out_acc=0x00000800 (1.0); out_count=3.
- Single pair (1.5, -1.0, last) → out_acc=0xFFFFF400 (-1.5); out_count=1.
- Back-to-back vectors [(1,1) last], [(1,1),(1,1) last], continuous valid → results 0x800 then 0x1000; no in_ready bubble.
- out_ready=0 with one result pending, next vector's last reaches S1 → in_ready=0; all state held; on out_ready=1, second result appears the next cycle; no loss or duplication.
- Assert reset for 1 cycle after 2 pairs of a vector → no output; next vector [(1,1) last] yields 0x800, count=1.
- 1030 pairs of (1.0, 1.0) with MAX_LEN=1024 → out_count=1024; out_acc=1030<<11.

Source files
------------

// File: rtl/float_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : float_mac_pkg
// Purpose  : Shared types and width helpers for the float MAC dot-product
//            sequencer. Package only; there are no ports.
//            - out_state_e        : output buffer state (empty / full)
//            - acc_frac()         : Kulisch fraction bits for the operand formats
//            - acc_non_frac()     : Kulisch integer bits (explicit or minimum+guard)
//            - acc_total()        : total Kulisch accumulator width
//            - fp_bias()          : exponent bias of a small float format
// Revision : 1.0 - initial release
// ============================================================================
package float_mac_pkg;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int acc_frac(input int ea, input int fa,
                                  input int eb, input int fb);
    return (fa + fb + 1) + (1 << (ea - 1)) + (1 << (eb - 1)) - 2;
  endfunction

  function automatic int acc_non_frac(input int desired, input int extra,
                                      input int ea, input int fa,
                                      input int eb, input int fb);
    if (desired != 0) return desired - acc_frac(ea, fa, eb, fb);
    return extra + 2 + (1 << (ea - 1)) + (1 << (eb - 1));
  endfunction

  function automatic int acc_total(input int desired, input int extra,
                                   input int ea, input int fa,
                                   input int eb, input int fb);
    return acc_frac(ea, fa, eb, fb) + acc_non_frac(desired, extra, ea, fa, eb, fb);
  endfunction

endpackage : float_mac_pkg
`default_nettype wire

// File: rtl/float_mac_dot_sequencer_fma.sv
`default_nettype none
// ============================================================================
// Module   : float_mac_dot_sequencer_fma
// Purpose  : Combinational exact float multiply + Kulisch add.
//            acc_o = acc_i + a_i * b_i, with the product aligned exactly onto
//            the fixed-point grid (ACC_FRAC fraction bits). All encodings are
//            finite: exp==0 is subnormal (no hidden bit), no inf/NaN codes.
// Ports    : a_i   [EA+FA:0]       float {sign, exp, frac}
//            b_i   [EB+FB:0]       float {sign, exp, frac}
//            acc_i [ACC_TOTAL-1:0] accumulator in, two's complement
//            acc_o [ACC_TOTAL-1:0] accumulator out, two's complement
// Revision : 1.0 - initial release
// ============================================================================
module float_mac_dot_sequencer_fma
  import float_mac_pkg::*;
#(
  parameter int EA                 = 3,
  parameter int FA                 = 2,
  parameter int EB                 = 3,
  parameter int FB                 = 2,
  parameter int TRAILING_BITS      = 2,
  parameter int ACC_FRAC           = 11,
  parameter int ACC_TOTAL          = 32,
  parameter int OVERFLOW_DETECTION = 0
) (
  input  logic [EA+FA:0]        a_i,
  input  logic [EB+FB:0]        b_i,
  input  logic [ACC_TOTAL-1:0]  acc_i,
  output logic [ACC_TOTAL-1:0]  acc_o
);

  localparam int PROD_W = (FA + 1) + (FB + 1);
  localparam int EXT_W  = PROD_W + TRAILING_BITS;
  // Exponent-to-shift offset: a product of significand integers carries
  // FA+FB fraction bits and the biased exponents; ACC_FRAC re-bases it.
  localparam int SHIFT_OFS = ACC_FRAC - FA - FB - fp_bias(EA) - fp_bias(EB);

  logic              w_sign;
  logic [EA-1:0]     w_exp_a;
  logic [EB-1:0]     w_exp_b;
  logic [EA-1:0]     w_ea_eff;
  logic [EB-1:0]     w_eb_eff;
  logic [FA:0]       w_sig_a;
  logic [FB:0]       w_sig_b;
  logic [PROD_W-1:0] w_prod;
  logic [EXT_W-1:0]  w_prod_ext;
  int                w_shift;
  logic [ACC_TOTAL-1:0] w_aligned;
  logic [ACC_TOTAL-1:0] w_addend;
  logic [ACC_TOTAL-1:0] w_sum;

  assign w_sign  = a_i[EA+FA] ^ b_i[EB+FB];
  assign w_exp_a = a_i[EA+FA-1:FA];
  assign w_exp_b = b_i[EB+FB-1:FB];

  // Subnormals share the exponent of the smallest normal, without hidden bit.
  assign w_sig_a  = {(w_exp_a != '0), a_i[FA-1:0]};
  assign w_sig_b  = {(w_exp_b != '0), b_i[FB-1:0]};
  assign w_ea_eff = (w_exp_a == '0) ? EA'(1) : w_exp_a;
  assign w_eb_eff = (w_exp_b == '0) ? EB'(1) : w_exp_b;

  assign w_prod     = PROD_W'(w_sig_a) * PROD_W'(w_sig_b);
  // The product is exact, so the trailing extension always holds zeros.
  assign w_prod_ext = EXT_W'(w_prod);
  assign w_shift    = int'(w_ea_eff) + int'(w_eb_eff) + SHIFT_OFS;
  assign w_aligned  = ACC_TOTAL'(w_prod_ext) << w_shift;
  assign w_addend   = w_sign ? (~w_aligned + ACC_TOTAL'(1)) : w_aligned;
  assign w_sum      = acc_i + w_addend;

  if (OVERFLOW_DETECTION != 0) begin : g_sat
    logic w_ovf;
    // Signed overflow: both operands share a sign the sum does not.
    assign w_ovf = (acc_i[ACC_TOTAL-1] == w_addend[ACC_TOTAL-1]) &&
                   (w_sum[ACC_TOTAL-1] != acc_i[ACC_TOTAL-1]);
    assign acc_o = !w_ovf ? w_sum :
                   (acc_i[ACC_TOTAL-1] ? {1'b1, {(ACC_TOTAL-1){1'b0}}}
                                       : {1'b0, {(ACC_TOTAL-1){1'b1}}});
  end else begin : g_wrap
    assign acc_o = w_sum;
  end

endmodule : float_mac_dot_sequencer_fma
`default_nettype wire

// File: rtl/float_mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : float_mac_dot_sequencer
// Purpose  : Streams (a, b) float pairs through one input register stage into
//            an exact Kulisch accumulator and emits one dot product per
//            vector (terminated by in_last) into a one-entry output buffer.
//            The accumulator restarts from zero with no bubble.
// Ports    : clock, reset            sole clock, synchronous active-high reset
//            in_valid/in_ready       operand handshake
//            in_a, in_b, in_last     operand pair and end-of-vector marker
//            out_valid/out_ready     result handshake
//            out_acc                 result, two's complement, ACC_FRAC frac bits
//            out_count               pairs in the vector, saturating at MAX_LEN
// Revision : 1.0 - initial release
// ============================================================================
module float_mac_dot_sequencer
  import float_mac_pkg::*;
#(
  parameter int EXP_IN_A           = 3,
  parameter int FRAC_IN_A          = 2,
  parameter int EXP_IN_B           = 3,
  parameter int FRAC_IN_B          = 2,
  parameter int TRAILING_BITS      = 2,
  parameter int ACC_DESIRED        = 32,
  parameter int ACC_EXTRA_BIT      = 8,
  parameter int OVERFLOW_DETECTION = 0,
  parameter int MAX_LEN            = 1024
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXP_IN_A+FRAC_IN_A:0]     in_a,
  input  logic [EXP_IN_B+FRAC_IN_B:0]     in_b,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [acc_total(ACC_DESIRED, ACC_EXTRA_BIT, EXP_IN_A, FRAC_IN_A,
                          EXP_IN_B, FRAC_IN_B)-1:0] out_acc,
  output logic [$clog2(MAX_LEN+1)-1:0]    out_count
);

  localparam int ACC_FRAC  = acc_frac(EXP_IN_A, FRAC_IN_A, EXP_IN_B, FRAC_IN_B);
  localparam int ACC_TOTAL = acc_total(ACC_DESIRED, ACC_EXTRA_BIT, EXP_IN_A,
                                       FRAC_IN_A, EXP_IN_B, FRAC_IN_B);
  localparam int CNT_W     = $clog2(MAX_LEN + 1);

  // S1 operand stage
  logic                        s1_valid_q;
  logic                        s1_last_q;
  logic [EXP_IN_A+FRAC_IN_A:0] s1_a_q;
  logic [EXP_IN_B+FRAC_IN_B:0] s1_b_q;

  // Running vector state and output buffer
  logic [ACC_TOTAL-1:0] acc_q;
  logic [ACC_TOTAL-1:0] acc_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 out_valid_q;
  logic [ACC_TOTAL-1:0] out_acc_q;
  logic [CNT_W-1:0]     out_count_q;
  out_state_e           state_q;

  logic stall;
  logic accept;
  logic retire;
  logic last_retire;

  // Only a finished vector waiting behind an unconsumed result must block;
  // non-last pairs can always fold into the accumulator.
  assign stall       = s1_valid_q && s1_last_q && out_valid_q && !out_ready;
  assign in_ready    = !stall;
  assign accept      = in_valid && in_ready;
  assign retire      = s1_valid_q && !stall;
  assign last_retire = retire && s1_last_q;

  assign cnt_d = (cnt_q == CNT_W'(MAX_LEN)) ? cnt_q : cnt_q + CNT_W'(1);

  float_mac_dot_sequencer_fma #(
    .EA                 (EXP_IN_A),
    .FA                 (FRAC_IN_A),
    .EB                 (EXP_IN_B),
    .FB                 (FRAC_IN_B),
    .TRAILING_BITS      (TRAILING_BITS),
    .ACC_FRAC           (ACC_FRAC),
    .ACC_TOTAL          (ACC_TOTAL),
    .OVERFLOW_DETECTION (OVERFLOW_DETECTION)
  ) u_fma (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .acc_i (acc_q),
    .acc_o (acc_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      state_q     <= OUT_EMPTY;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_last_q  <= in_last;
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
      end else if (retire) begin
        s1_valid_q <= 1'b0;
        s1_last_q  <= 1'b0;
      end

      if (retire) begin
        if (s1_last_q) begin
          // Hand the finished sum over and restart so the next vector's
          // first pair can retire in the very next cycle.
          out_acc_q   <= acc_d;
          out_count_q <= cnt_d;
          acc_q       <= '0;
          cnt_q       <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
      end

      case (state_q)
        OUT_EMPTY: begin
          if (last_retire) begin
            state_q     <= OUT_FULL;
            out_valid_q <= 1'b1;
          end
        end
        OUT_FULL: begin
          // A last retiring while full implies out_ready, so the buffer
          // is refilled in place.
          if (!last_retire && out_ready) begin
            state_q     <= OUT_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= OUT_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;

endmodule : float_mac_dot_sequencer
`default_nettype wire

// File: tb/tb_float_mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_mac_dot_sequencer
// Purpose  : Scoreboard bench for float_mac_dot_sequencer with default
//            parameters (3/2 floats, 32-bit accumulator, 11 fraction bits).
//            Float codes used: 0x0C=1.0 0x10=2.0 0x08=0.5 0x28=-0.5
//            0x0E=1.5 0x2C=-1.0 0x01=2^-4 0x1F=28.0 0x20=-0.0
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_mac_dot_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_a;
  logic [5:0]  in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_acc;
  logic [10:0] out_count;

  typedef struct packed {
    logic [31:0] acc;
    logic [10:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   w;

  always #5 clock = ~clock;

  float_mac_dot_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] acc, input logic [10:0] cnt);
    exp_t e;
    e.acc = acc;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the pair is accepted.
  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic last,
                      output int waits);
    bit ok;
    ok       = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!ok && waits <= 200) begin
      #1;
      ok = (in_ready === 1'b1);
      if (!ok) waits++;
      @(negedge clock);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: a transfer happens at the coming posedge when both are high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=0x%0h required=none", out_acc);
        end else begin
          e = sb_q.pop_front();
          chk("result_acc", 64'(out_acc), 64'(e.acc));
          chk("result_count", 64'(out_count), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_acc", 64'(out_acc), 64'd0);
    chk("reset_out_count", 64'(out_count), 64'd0);
    mon_en = 1'b1;
    @(negedge clock);

    // 1.0*1.0 + 2.0*0.5 + (-0.5)*2.0 = 1.0; out_valid two cycles after last accept
    push(32'h0000_0800, 11'd3);
    send(6'h0C, 6'h0C, 1'b0, w);
    send(6'h10, 6'h08, 1'b0, w);
    send(6'h28, 6'h10, 1'b1, w);
    idle();
    #1;
    chk("latency_t1_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    #1;
    chk("latency_t2_valid", 64'(out_valid), 64'd1);
    @(negedge clock);

    // Single-pair vector: 1.5 * -1.0
    push(32'hFFFF_F400, 11'd1);
    send(6'h0E, 6'h2C, 1'b1, w);
    idle();
    repeat (3) @(negedge clock);

    // Subnormal, signed zero and largest code: 2^-8 + 0 + 784
    push(32'h0018_8008, 11'd3);
    send(6'h01, 6'h01, 1'b0, w);
    send(6'h20, 6'h1F, 1'b0, w);
    send(6'h1F, 6'h1F, 1'b1, w);
    idle();
    repeat (3) @(negedge clock);

    // Back-to-back vectors with continuous valid: no in_ready bubble
    push(32'h0000_0800, 11'd1);
    push(32'h0000_1000, 11'd2);
    send(6'h0C, 6'h0C, 1'b1, w);
    chk("no_bubble_0", 64'(w), 64'd0);
    send(6'h0C, 6'h0C, 1'b0, w);
    chk("no_bubble_1", 64'(w), 64'd0);
    send(6'h0C, 6'h0C, 1'b1, w);
    chk("no_bubble_2", 64'(w), 64'd0);
    idle();
    repeat (3) @(negedge clock);

    // Backpressure: result A pending, B's last in S1, C waits at the input
    out_ready = 1'b0;
    push(32'h0000_0800, 11'd1);
    send(6'h0C, 6'h0C, 1'b1, w);
    idle();
    repeat (2) @(negedge clock);
    push(32'h0000_2000, 11'd1);
    send(6'h10, 6'h10, 1'b1, w);
    push(32'h0000_0800, 11'd1);
    in_valid = 1'b1;
    in_a     = 6'h0C;
    in_b     = 6'h0C;
    in_last  = 1'b1;
    #1;
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("stall_in_ready_hold", 64'(in_ready), 64'd0);
      chk("stall_acc_hold", 64'(out_acc), 64'h800);
      chk("stall_valid_hold", 64'(out_valid), 64'd1);
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    idle();
    #1;
    chk("release_next_valid", 64'(out_valid), 64'd1);
    chk("release_next_acc", 64'(out_acc), 64'h2000);
    @(negedge clock);
    repeat (3) @(negedge clock);

    // Reset with a result pending and a vector half done
    out_ready = 1'b0;
    send(6'h0C, 6'h0C, 1'b1, w);
    send(6'h0C, 6'h0C, 1'b0, w);
    send(6'h0C, 6'h0C, 1'b0, w);
    idle();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    push(32'h0000_0800, 11'd1);
    send(6'h0C, 6'h0C, 1'b1, w);
    idle();
    repeat (3) @(negedge clock);

    // Count saturation: 1030 pairs of 1.0*1.0
    push(32'h0020_3000, 11'd1024);
    for (int i = 0; i < 1030; i++) begin
      send(6'h0C, 6'h0C, (i == 1029), w);
    end
    idle();
    repeat (3) @(negedge clock);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_float_mac_dot_sequencer
`default_nettype wire
